axis_out_fifo: RTL and testbench
================================

AXIS_OUT_FIFO -- requirements
Module: axis_out_fifo

Interface
REQ-001 The block SHALL have parameter pDATA_WIDTH, default 32, giving the stream data width.
REQ-002 The block SHALL have parameter pDEPTH, default 16, giving the number of entries (power of 2, minimum 2).
REQ-003 The block SHALL have port axis_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port axis_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port clr  input  1  synchronous flush request.
REQ-006 The block SHALL have port s_tvalid  input  1  upstream beat valid (driven by FIR sm_tvalid).
REQ-007 The block SHALL have port s_tdata  input  pDATA_WIDTH  upstream data (FIR sm_tdata).
REQ-008 The block SHALL have port s_tlast  input  1  upstream end of frame (FIR sm_tlast).
REQ-009 The block SHALL have port s_tready  output  1  the block can accept a beat (drives FIR sm_tready).
REQ-010 The block SHALL have ports m_tvalid (output, 1), m_tdata (output, pDATA_WIDTH), m_tlast (output, 1) and m_tready (input, 1), forming the downstream AXI-Stream master.
REQ-011 The block SHALL have port level  output  log2(pDEPTH)+1  current occupancy.
REQ-012 The block SHALL have ports full and empty  output  1 each  occupancy flags.
REQ-013 The block SHALL have port frame_cnt  output  16  number of frames fully delivered downstream.
REQ-014 The block SHALL have port in_frame  output  1  a frame has started downstream but its tlast beat has not yet transferred.

Function
REQ-015 Push SHALL occur when s_tvalid && s_tready && !clr; it stores {s_tlast, s_tdata} at wr_ptr.
REQ-016 Pop SHALL occur when m_tvalid && m_tready && !clr; it advances rd_ptr.
REQ-017 s_tready SHALL equal !full and SHALL NOT depend combinationally on m_tready or s_tvalid.
REQ-018 m_tvalid SHALL equal !empty; m_tdata and m_tlast SHALL be read from mem[rd_ptr] (first-word fall-through).
REQ-019 Latency: a beat pushed at edge N SHALL be visible on m_* after edge N when the FIFO was empty.
REQ-020 m_tdata and m_tlast SHALL remain stable while m_tvalid=1 and m_tready=0.
REQ-021 wr_ptr and rd_ptr SHALL wrap from pDEPTH-1 to 0.
REQ-022 level SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-023 full SHALL be asserted when level==pDEPTH, and empty SHALL be asserted when level==0.
REQ-024 When full, no push SHALL occur even if a pop happens in the same cycle; the upstream beat is held.
REQ-025 Beats SHALL be delivered in order, with tlast preserved bit-exactly; no data is dropped or duplicated.
REQ-026 Frame tracking SHALL be a two-state FSM: IDLE to INFRAME on a pop with m_tlast=0; INFRAME to IDLE on a pop with m_tlast=1; a tlast pop while in IDLE (one-beat frame) stays in IDLE.
REQ-027 in_frame SHALL be 1 exactly in state INFRAME.
REQ-028 frame_cnt SHALL increment on every pop with m_tlast=1 and saturate at 16'hFFFF.
REQ-029 clr SHALL have priority over push and pop: at the next edge, pointers, level and frame_cnt go to 0, the FSM goes to IDLE, and the beat present that cycle is neither stored nor consumed.

Reset
REQ-030 On axis_rst_n=0, pointers, level, frame_cnt and the FSM SHALL clear immediately (asynchronously).
REQ-031 Output values during and after reset SHALL be: m_tvalid=0, s_tready=1, empty=1, full=0, in_frame=0; memory contents need not be cleared.
REQ-032 A reset asserted mid-frame SHALL discard all stored beats.
REQ-033 After deassertion, the first push SHALL be accepted on the first rising edge.

Structure
REQ-034 The shared package fir_pkg SHALL hold pDATA_WIDTH and the default depth constants, plus the FSM state encoding (IDLE=0, INFRAME=1).
REQ-035 Storage SHALL be a sub-module axis_fifo_mem (pDEPTH x (pDATA_WIDTH+1), one write port, one asynchronous read port); pointer and control logic SHALL stay in axis_out_fifo.

Verification
REQ-036 Reset check: after reset release with no stimulus -> m_tvalid=0, s_tready=1, level=0, empty=1, frame_cnt=0.
REQ-037 Fill check: push 1..16 with m_tready=0 -> level=16, full=1, s_tready=0; a 17th beat (value 17) is held upstream, not stored.
REQ-038 Drain check: from the full state, hold m_tready=1 -> m_tdata 1..16 on consecutive cycles, then value 17 accepted, empty=1 at the end.
REQ-039 Simultaneous check: at level=5, push and pop in the same cycle -> level stays 5 and output order is unchanged.
REQ-040 Frame check: a 64-beat frame with tlast on beat 64 and random m_tready -> m_tlast=1 only on beat 64, in_frame high from beat 1 pop through beat 64 pop, frame_cnt=1.
REQ-041 Flush check: at level=7 with s_tvalid=1, assert clr for one cycle -> next cycle level=0, m_tvalid=0, frame_cnt=0, and the beat is not stored.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and frame-tracking state encoding for the FIR output path
package fir_pkg;

    localparam int FIR_DATA_WIDTH    = 32;
    localparam int FIR_OUT_DEPTH     = 16;
    localparam int FIR_OUT_DEPTH_MIN = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        INFRAME = 1'b1
    } frame_state_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// rtl/axis_fifo_mem.sv - FIFO storage array, one synchronous write port, one asynchronous read port
module axis_fifo_mem
    import fir_pkg::*;
#(
    parameter int pWIDTH = FIR_DATA_WIDTH + 1,
    parameter int pDEPTH = FIR_OUT_DEPTH
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [$clog2(pDEPTH)-1:0] waddr,
    input  logic [pWIDTH-1:0]         wdata,
    input  logic [$clog2(pDEPTH)-1:0] raddr,
    output logic [pWIDTH-1:0]         rdata
);

    // Contents are deliberately not reset; validity is tracked by the pointers.
    logic [pWIDTH-1:0] mem [pDEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_out_fifo.sv
// rtl/axis_out_fifo.sv - first-word fall-through stream FIFO with frame tracking on the output side
module axis_out_fifo
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = FIR_DATA_WIDTH,
    parameter int pDEPTH      = FIR_OUT_DEPTH
) (
    input  logic                      axis_clk,
    input  logic                      axis_rst_n,
    input  logic                      clr,
    input  logic                      s_tvalid,
    input  logic [pDATA_WIDTH-1:0]    s_tdata,
    input  logic                      s_tlast,
    output logic                      s_tready,
    output logic                      m_tvalid,
    output logic [pDATA_WIDTH-1:0]    m_tdata,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [$clog2(pDEPTH):0]   level,
    output logic                      full,
    output logic                      empty,
    output logic [15:0]               frame_cnt,
    output logic                      in_frame
);

    localparam int AW = $clog2(pDEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(pDEPTH);

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [pDATA_WIDTH:0] rd_word;
    logic                 push;
    logic                 pop;
    frame_state_t         state;

    // Flags come straight from the level register so s_tready never sees m_tready.
    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    assign s_tready = !full;
    assign m_tvalid = !empty;

    assign push = s_tvalid && s_tready && !clr;
    assign pop  = m_tvalid && m_tready && !clr;

    assign m_tlast  = rd_word[pDATA_WIDTH];
    assign m_tdata  = rd_word[pDATA_WIDTH-1:0];
    assign in_frame = (state == INFRAME);

    axis_fifo_mem #(
        .pWIDTH (pDATA_WIDTH + 1),
        .pDEPTH (pDEPTH)
    ) u_mem (
        .clk   (axis_clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({s_tlast, s_tdata}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            frame_cnt <= '0;
            state     <= IDLE;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            frame_cnt <= '0;
            state     <= IDLE;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (pop) begin
                if (m_tlast) begin
                    state <= IDLE;
                    if (frame_cnt != 16'hFFFF) begin
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end else begin
                    state <= INFRAME;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_out_fifo.sv
// tb/tb_axis_out_fifo.sv - scoreboard testbench for axis_out_fifo
`timescale 1ns/1ps
module tb_axis_out_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n;
    logic          clr;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic          s_tready;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tready;
    logic [4:0]    level;
    logic          full;
    logic          empty;
    logic [15:0]   frame_cnt;
    logic          in_frame;

    int vectors   = 0;
    int miscompares = 0;

    logic [DW:0] sb_q[$];
    int          model_level = 0;
    logic        model_in_frame = 1'b0;
    logic [15:0] model_frame_cnt = 16'd0;
    logic        rand_rdy = 1'b0;

    axis_out_fifo #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .clr        (clr),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .frame_cnt  (frame_cnt),
        .in_frame   (in_frame)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the model, then advance the model for the coming edge.
    always @(negedge axis_clk) begin
        if (!axis_rst_n) begin
            sb_q.delete();
            model_level     = 0;
            model_in_frame  = 1'b0;
            model_frame_cnt = 16'd0;
        end else begin
            logic do_push;
            logic do_pop;
            check("level", 64'(level), 64'(model_level));
            check("s_tready", 64'(s_tready), 64'(model_level != DEPTH));
            check("m_tvalid", 64'(m_tvalid), 64'(model_level != 0));
            check("in_frame", 64'(in_frame), 64'(model_in_frame));
            check("frame_cnt", 64'(frame_cnt), 64'(model_frame_cnt));
            if (model_level != 0 && sb_q.size() != 0) begin
                check("m_tdata", 64'(m_tdata), 64'(sb_q[0][DW-1:0]));
                check("m_tlast", 64'(m_tlast), 64'(sb_q[0][DW]));
            end
            do_push = s_tvalid && (model_level != DEPTH) && !clr;
            do_pop  = m_tready && (model_level != 0) && !clr;
            if (clr) begin
                sb_q.delete();
                model_level     = 0;
                model_in_frame  = 1'b0;
                model_frame_cnt = 16'd0;
            end else begin
                if (do_pop) begin
                    logic [DW:0] w;
                    w = sb_q.pop_front();
                    if (w[DW]) begin
                        model_in_frame = 1'b0;
                        if (model_frame_cnt != 16'hFFFF) model_frame_cnt = model_frame_cnt + 16'd1;
                    end else begin
                        model_in_frame = 1'b1;
                    end
                    model_level--;
                end
                if (do_push) begin
                    sb_q.push_back({s_tlast, s_tdata});
                    model_level++;
                end
            end
        end
    end

    always @(posedge axis_clk) begin
        if (rand_rdy) begin
            #1 m_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic l);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        for (n = 0; n < 500; n++) begin
            @(negedge axis_clk);
            if (s_tready) break;
        end
        check("send_timeout", 64'(n < 500), 64'd1);
        @(posedge axis_clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        for (n = 0; n < 2000 && model_level != 0; n++) @(posedge axis_clk);
        check("drain_timeout", 64'(model_level), 64'd0);
        #1;
    endtask

    initial begin
        axis_rst_n = 1'b0;
        clr        = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        m_tready   = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1 axis_rst_n = 1'b1;
        repeat (2) @(posedge axis_clk);
        #1;
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd1);
        check("rst_level", 64'(level), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);

        // Fill to capacity, then hold a 17th beat upstream.
        for (int i = 1; i <= 16; i++) send(DW'(i), 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = DW'(17);
        s_tlast  = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;
        check("fill_level", 64'(level), 64'd16);
        check("fill_full", 64'(full), 64'd1);
        check("fill_s_tready", 64'(s_tready), 64'd0);

        m_tready = 1'b1;
        send(DW'(17), 1'b0);
        wait_empty();
        check("drain_empty", 64'(empty), 64'd1);
        m_tready = 1'b0;

        for (int i = 0; i < 5; i++) send(DW'(100 + i), 1'b0);
        check("sim_level_pre", 64'(level), 64'd5);
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = DW'(105);
        @(posedge axis_clk);
        #1;
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        check("sim_level", 64'(level), 64'd5);
        check("sim_head", 64'(m_tdata), 64'd101);
        m_tready = 1'b1;
        wait_empty();
        m_tready = 1'b0;

        rand_rdy = 1'b1;
        for (int i = 1; i <= 64; i++) send(DW'(1000 + i), i == 64);
        wait_empty();
        rand_rdy = 1'b0;
        @(posedge axis_clk);
        #2 m_tready = 1'b0;
        check("frame_cnt_1", 64'(frame_cnt), 64'd1);
        check("frame_idle", 64'(in_frame), 64'd0);

        for (int i = 0; i < 7; i++) send(DW'(200 + i), 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = DW'(299);
        clr      = 1'b1;
        @(posedge axis_clk);
        #1;
        clr      = 1'b0;
        s_tvalid = 1'b0;
        check("flush_level", 64'(level), 64'd0);
        check("flush_m_tvalid", 64'(m_tvalid), 64'd0);
        check("flush_frame_cnt", 64'(frame_cnt), 64'd0);
        send(DW'(300), 1'b1);
        check("post_flush_head", 64'(m_tdata), 64'd300);
        m_tready = 1'b1;
        wait_empty();
        m_tready = 1'b0;

        // Reset mid-frame: stored beats are discarded and the FSM returns to IDLE.
        for (int i = 0; i < 3; i++) send(DW'(400 + i), 1'b0);
        m_tready = 1'b1;
        @(posedge axis_clk);
        #1 m_tready = 1'b0;
        check("mid_in_frame", 64'(in_frame), 64'd1);
        axis_rst_n = 1'b0;
        #1;
        check("arst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("arst_s_tready", 64'(s_tready), 64'd1);
        check("arst_full", 64'(full), 64'd0);
        check("arst_in_frame", 64'(in_frame), 64'd0);
        @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        s_tvalid   = 1'b1;
        s_tdata    = DW'(500);
        s_tlast    = 1'b0;
        @(posedge axis_clk);
        #1;
        s_tvalid = 1'b0;
        check("first_push_level", 64'(level), 64'd1);
        check("first_push_data", 64'(m_tdata), 64'd500);
        m_tready = 1'b1;
        wait_empty();
        m_tready = 1'b0;
        repeat (2) @(posedge axis_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
